sdram_stream_reader: RTL and testbench

- Avalon-MM read master driving the SDRAM controller's s1 slave port: 24-bit word address, 16-bit data, active-low read_n/write_n/byteenable_n, waitrequest, pipelined readdatavalid.
- On a start command, fetches LEN consecutive 16-bit words from a base address and presents them on a valid/ready stream, e.g. to feed voxel slice data to the display driver.
- Outstanding-read credit counting guarantees the internal FIFO never overflows, regardless of consumer stalls.

---
 rtl/sdram_stream_reader.sv | 165 ++++++++++++++++
 tb/tb_sdram_stream_reader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_stream_reader.sv
// rtl/sdram_stream_reader.sv - Avalon-MM read master streaming consecutive SDRAM words out on valid/ready
//
// Ports:
//   clk_clk, reset_reset          : sole clock, synchronous active-high reset
//   start, base_addr, length      : transfer command (sampled when idle)
//   busy, done, err               : status; done is a one-cycle pulse, err is sticky
//   avm_*                         : Avalon-MM master towards the SDRAM controller s1 port
//   out_data, out_valid, out_ready: first-word-fall-through output stream
module sdram_stream_reader #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 16,
    parameter int LEN_W       = 24,
    parameter int FIFO_DEPTH  = 16,
    parameter int MAX_PENDING = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] avm_address,
    output logic [1:0]        avm_byteenable_n,
    output logic              avm_chipselect,
    output logic [DATA_W-1:0] avm_writedata,
    output logic              avm_read_n,
    output logic              avm_write_n,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              avm_waitrequest,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PEND_W = $clog2(MAX_PENDING + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  received;
    logic [PEND_W-1:0] pending;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic              accept;
    logic              push;
    logic              pop;
    logic              credit_ok;
    logic [PEND_W-1:0] pending_next;
    logic [CNT_W-1:0]  fifo_count_next;
    logic [LEN_W-1:0]  issued_next;

    assign avm_byteenable_n = 2'b00;
    assign avm_writedata    = '0;
    assign avm_write_n      = 1'b1;

    assign accept    = avm_chipselect & ~avm_read_n & ~avm_waitrequest;
    // A beat with nothing outstanding belongs to no request of ours and is dropped.
    assign push      = avm_readdatavalid && (pending != '0);
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    assign pending_next    = pending + PEND_W'(accept) - PEND_W'(push);
    assign fifo_count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign issued_next     = issued + LEN_W'(accept);

    // Every issued read reserves a FIFO slot until its word is popped, so
    // pending + fifo_count bounds the FIFO occupancy whatever the consumer does.
    assign credit_ok = (int'(pending_next) < MAX_PENDING) &&
                       (int'(pending_next) + int'(fifo_count_next) < FIFO_DEPTH);

    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem[wr_ptr] <= avm_readdata;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_read_n     <= 1'b1;
            avm_address    <= '0;
            len            <= '0;
            issued         <= '0;
            received       <= '0;
            pending        <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
        end else begin
            done       <= 1'b0;
            pending    <= pending_next;
            fifo_count <= fifo_count_next;
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                received <= received + LEN_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (avm_readdatavalid && (pending == '0) && busy) begin
                err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (length != '0) begin
                            len            <= length;
                            avm_address    <= base_addr;
                            issued         <= '0;
                            received       <= '0;
                            err            <= 1'b0;
                            avm_chipselect <= 1'b1;
                            avm_read_n     <= 1'b0;
                            state          <= ISSUE;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        avm_address <= avm_address + ADDR_W'(1);
                        issued      <= issued_next;
                    end
                    if (accept && (issued_next == len)) begin
                        avm_chipselect <= 1'b0;
                        avm_read_n     <= 1'b1;
                        state          <= DRAIN;
                    end else if (!avm_chipselect || accept) begin
                        // A stalled request is left untouched until the slave takes it.
                        avm_chipselect <= credit_ok;
                        avm_read_n     <= ~credit_ok;
                    end
                end
                DRAIN: begin
                    if ((received == len) && (fifo_count == '0)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_stream_reader.sv
// tb/tb_sdram_stream_reader.sv - self-checking bench for sdram_stream_reader with an Avalon slave model
module tb_sdram_stream_reader;
    logic        clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic        start = 1'b0;
    logic [23:0] base_addr = '0;
    logic [23:0] length = '0;
    logic        busy, done, err;
    logic [23:0] avm_address;
    logic [1:0]  avm_byteenable_n;
    logic        avm_chipselect;
    logic [15:0] avm_writedata;
    logic        avm_read_n, avm_write_n;
    logic [15:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;

    always #5 clk = ~clk;

    sdram_stream_reader dut (
        .clk_clk(clk), .reset_reset(reset_reset), .start(start),
        .base_addr(base_addr), .length(length), .busy(busy), .done(done), .err(err),
        .avm_address(avm_address), .avm_byteenable_n(avm_byteenable_n),
        .avm_chipselect(avm_chipselect), .avm_writedata(avm_writedata),
        .avm_read_n(avm_read_n), .avm_write_n(avm_write_n),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .avm_waitrequest(avm_waitrequest), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    typedef struct {
        logic [23:0] base;
        int len;
        int lat;
        int stall_idx;
        int stall_len;
        int ready_hold;
        int exp_gap;
        int exp_pend;
        int exp_infl;
    } vec_t;

    typedef struct {
        logic [23:0] addr;
        int due;
    } rsp_t;

    int errors = 0;
    int checks = 0;

    rsp_t        rsp_q[$];
    logic [23:0] exp_addr[$];
    logic [15:0] exp_data[$];
    vec_t        vecs[5];

    int neg_cnt = 0, lat = 2, stall_idx = -1, stall_len = 0, stall_ctr = 0, ready_hold = 0;
    int acc_cnt = 0, pop_cnt = 0, done_cnt = 0, cs_cnt = 0, valid_cnt = 0;
    int last_acc = 0, max_gap = 0, max_pend = 0, max_infl = 0;
    bit ignore_addr = 1'b0;
    bit prev_stall = 1'b0;
    logic [23:0] prev_addr = '0;

    function automatic logic [15:0] model(input logic [23:0] a);
        return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h5A3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model, stream consumer and scoreboard; everything here acts on the
    // falling edge for the rising edge that follows.
    always @(negedge clk) begin
        logic req;
        logic wr;
        rsp_t r;
        logic [23:0] ea;
        neg_cnt++;
        if (prev_stall) begin
            check("hold_stable", {6'd0, avm_chipselect, avm_read_n, avm_address}, {6'd0, 1'b1, 1'b0, prev_addr});
        end
        if (rsp_q.size() > 0 && rsp_q[0].due <= neg_cnt) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = model(rsp_q[0].addr);
            void'(rsp_q.pop_front());
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata = '0;
        end
        req = avm_chipselect && !avm_read_n;
        wr = req && (acc_cnt == stall_idx) && (stall_ctr < stall_len);
        if (wr) stall_ctr++;
        avm_waitrequest = wr;
        prev_stall = wr;
        prev_addr = avm_address;
        if (req) cs_cnt++;
        if (req && !wr) begin
            r.addr = avm_address;
            r.due = neg_cnt + lat;
            rsp_q.push_back(r);
            if (!ignore_addr) begin
                check("addr_expected", {31'd0, exp_addr.size() != 0}, 32'd1);
                if (exp_addr.size() != 0) begin
                    ea = exp_addr.pop_front();
                    check("addr", {8'd0, avm_address}, {8'd0, ea});
                end
            end
            if (acc_cnt > 0 && (neg_cnt - last_acc) > max_gap) max_gap = neg_cnt - last_acc;
            last_acc = neg_cnt;
            acc_cnt++;
        end
        if (rsp_q.size() > max_pend) max_pend = rsp_q.size();
        out_ready = (ready_hold == 0);
        if (ready_hold > 0) ready_hold--;
        if (out_valid) valid_cnt++;
        if (out_valid && out_ready) begin
            pop_cnt++;
            check("data_expected", {31'd0, exp_data.size() != 0}, 32'd1);
            if (exp_data.size() != 0) begin
                check("data", {16'd0, out_data}, {16'd0, exp_data.pop_front()});
            end
        end
        if ((acc_cnt - pop_cnt) > max_infl) max_infl = acc_cnt - pop_cnt;
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        acc_cnt = 0; pop_cnt = 0; done_cnt = 0; cs_cnt = 0; valid_cnt = 0;
        max_gap = 0; max_pend = 0; max_infl = 0; stall_ctr = 0;
    endtask

    task automatic begin_xfer(input logic [23:0] b, input int n);
        clear_stats();
        for (int i = 0; i < n; i++) begin
            logic [23:0] a;
            a = b + 24'(i);
            exp_addr.push_back(a);
            exp_data.push_back(model(a));
        end
        start = 1'b1;
        base_addr = b;
        length = 24'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int n);
        int t;
        t = 0;
        while (done_cnt == 0 && t < 1000) begin
            tick();
            t++;
        end
        check({name, "_timeout"}, {31'd0, t < 1000}, 32'd1);
        repeat (3) tick();
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_busy"}, {31'd0, busy}, 0);
        check({name, "_err"}, {31'd0, err}, 0);
        check({name, "_words"}, pop_cnt, n);
        check({name, "_addr_left"}, exp_addr.size(), 0);
        check({name, "_data_left"}, exp_data.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, {31'd0, busy}, 0);
        check({name, "_done"}, {31'd0, done}, 0);
        check({name, "_err"}, {31'd0, err}, 0);
        check({name, "_cs"}, {31'd0, avm_chipselect}, 0);
        check({name, "_read_n"}, {31'd0, avm_read_n}, 1);
        check({name, "_address"}, {8'd0, avm_address}, 0);
        check({name, "_out_valid"}, {31'd0, out_valid}, 0);
    endtask

    initial begin
        int t;
        //          base        len lat stall_idx stall_len hold gap pend infl
        vecs[0] = '{24'h000100,  4,  2,  -1,       0,        0,   1,  0,   0};
        vecs[1] = '{24'h002000, 20,  2,  -1,       0,       60,   0,  0,  16};
        vecs[2] = '{24'h000300,  6,  2,   1,       3,        0,   4,  0,   0};
        vecs[3] = '{24'hFFFFFE,  4,  2,  -1,       0,        0,   1,  0,   0};
        vecs[4] = '{24'h000040, 24, 12,  -1,       0,        0,   0,  8,   0};

        reset_reset = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        check("reset_byteenable_n", {30'd0, avm_byteenable_n}, 0);
        check("reset_write_n", {31'd0, avm_write_n}, 1);
        check("reset_writedata", {16'd0, avm_writedata}, 0);
        reset_reset = 1'b0;
        tick();

        for (int v = 0; v < 5; v++) begin
            lat = vecs[v].lat;
            stall_idx = vecs[v].stall_idx;
            stall_len = vecs[v].stall_len;
            ready_hold = vecs[v].ready_hold;
            begin_xfer(vecs[v].base, vecs[v].len);
            wait_done($sformatf("vec%0d", v), vecs[v].len);
            if (vecs[v].exp_gap > 0) check($sformatf("vec%0d_max_gap", v), max_gap, vecs[v].exp_gap);
            if (vecs[v].exp_pend > 0) check($sformatf("vec%0d_max_pend", v), max_pend, vecs[v].exp_pend);
            else check($sformatf("vec%0d_pend_bound", v), {31'd0, max_pend <= 8}, 1);
            if (vecs[v].exp_infl > 0) check($sformatf("vec%0d_max_inflight", v), max_infl, vecs[v].exp_infl);
            else check($sformatf("vec%0d_inflight_bound", v), {31'd0, max_infl <= 16}, 1);
            stall_idx = -1;
            stall_len = 0;
        end

        // Zero-length command: no bus traffic, done two cycles after start.
        clear_stats();
        lat = 2;
        start = 1'b1; base_addr = 24'h000123; length = 24'd0;
        tick();
        start = 1'b0;
        check("len0_busy", {31'd0, busy}, 1);
        check("len0_done_early", {31'd0, done}, 0);
        tick();
        check("len0_done", {31'd0, done}, 1);
        tick();
        check("len0_done_end", {31'd0, done}, 0);
        check("len0_done_pulses", done_cnt, 1);
        check("len0_no_cs", cs_cnt, 0);

        // Start strobe while busy must be ignored.
        begin_xfer(24'h000500, 4);
        tick();
        start = 1'b1; base_addr = 24'h000900; length = 24'd7;
        tick();
        start = 1'b0;
        wait_done("busy_start", 4);
        repeat (8) tick();
        check("busy_start_reads", cs_cnt, 4);
        check("busy_start_idle", {31'd0, busy}, 0);

        // Reset with reads outstanding; their late beats must be discarded silently.
        lat = 8;
        begin_xfer(24'h000700, 20);
        t = 0;
        while (rsp_q.size() < 3 && t < 50) begin
            tick();
            t++;
        end
        check("rst_pending_reached", {31'd0, rsp_q.size() >= 3}, 1);
        ignore_addr = 1'b1;
        reset_reset = 1'b1;
        tick();
        check_reset_outputs("rst_mid");
        reset_reset = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        clear_stats();
        t = 0;
        while (rsp_q.size() > 0 && t < 50) begin
            tick();
            t++;
        end
        tick();
        check("rst_strays_drained", rsp_q.size(), 0);
        check("rst_no_valid", valid_cnt, 0);
        check("rst_err", {31'd0, err}, 0);
        check("rst_no_cs", cs_cnt, 0);
        ignore_addr = 1'b0;
        lat = 2;
        begin_xfer(24'h000800, 2);
        wait_done("after_rst", 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
